memory_access_sequencer: RTL and testbench

Sequences every data-side load/store through the 2.5-port `MemoryController`. It drives `memoryMode` so that stores always run the required STORE_PRELOAD -> STORE read-modify-write pair, and it suppresses the write cycle when the controller flags an alignment or funct3 error. It gives the core a ready/valid request and a one-cycle response pulse. It sits between the core's execute stage and `MemoryController`; instruction fetch is not routed through it.

---
 rtl/memory_access_sequencer_pkg.sv | 16 +
 rtl/memory_access_sequencer_error_counter.sv | 24 ++
 rtl/memory_access_sequencer.sv | 95 +++++++++
 tb/tb_memory_access_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/memory_access_sequencer_pkg.sv
// Shared core types: controller memory modes and the data-side sequencer states.
package JZJCoreFTypes;

    typedef enum logic [1:0] {
        LOAD          = 2'b00,
        STORE_PRELOAD = 2'b01,
        STORE         = 2'b10
    } MemoryMode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WRITE   = 2'b01,
        RESPOND = 2'b10
    } MemSeqState_t;

endpackage

// File: rtl/memory_access_sequencer_error_counter.sv
// Saturating count of rejected requests plus a sticky flag; both clear only on reset.
module saturating_error_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             incEnable,
    output logic [WIDTH-1:0] count,
    output logic             sticky
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            sticky <= 1'b0;
        end else if (incEnable) begin
            sticky <= 1'b1;
            if (count != {WIDTH{1'b1}}) begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/memory_access_sequencer.sv
// Data-side load/store sequencer in front of MemoryController: enforces the
// STORE_PRELOAD -> STORE pair, drops the write on controller errors, pulses a response.
module memory_access_sequencer
    import JZJCoreFTypes::*;
#(
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       reqValid,
    input  logic                       reqStore,
    input  logic [2:0]                 reqFunct3,
    output logic                       reqReady,
    output logic                       respValid,
    output logic                       respError,
    output logic                       busy,
    output MemoryMode_t                memoryMode,
    output logic [2:0]                 funct3,
    input  logic                       memoryUnalignedAccess,
    input  logic                       memoryBadFunct3,
    output logic                       stickyError,
    output logic [ERR_COUNT_WIDTH-1:0] errorCount
);

    MemSeqState_t state;
    logic [2:0]   funct3Latched;
    logic         errLatched;
    logic         acceptErr;

    assign acceptErr = memoryUnalignedAccess | memoryBadFunct3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            errLatched <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        errLatched <= acceptErr;
                        // An erroring store skips WRITE entirely so no STORE is ever issued
                        state      <= (reqStore && !acceptErr) ? WRITE : RESPOND;
                    end
                end
                WRITE:   state <= RESPOND;
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // funct3 is pure data and only observed once latched, so it carries no reset
    always_ff @(posedge clock) begin
        if (state == IDLE && reqValid) begin
            funct3Latched <= reqFunct3;
        end
    end

    // Decoded straight from state so that reset pulls memoryMode out of STORE at once
    always_comb begin
        reqReady   = 1'b0;
        respValid  = 1'b0;
        respError  = 1'b0;
        busy       = 1'b1;
        memoryMode = LOAD;
        funct3     = funct3Latched;
        case (state)
            IDLE: begin
                reqReady   = 1'b1;
                busy       = 1'b0;
                memoryMode = (reqValid && reqStore) ? STORE_PRELOAD : LOAD;
                funct3     = reqFunct3;
            end
            WRITE: begin
                memoryMode = STORE;
            end
            RESPOND: begin
                respValid = 1'b1;
                respError = errLatched;
            end
            default: ;
        endcase
    end

    saturating_error_counter #(
        .WIDTH(ERR_COUNT_WIDTH)
    ) errorCounter (
        .clock    (clock),
        .reset    (reset),
        .incEnable(state == RESPOND && errLatched),
        .count    (errorCount),
        .sticky   (stickyError)
    );

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Scoreboarded bench for memory_access_sequencer with a small behavioural MemoryController model.
module tb_memory_access_sequencer;
    import JZJCoreFTypes::*;

    typedef struct {
        logic        err;
        logic        chkData;
        logic [31:0] data;
        int          cyc;
    } Resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqStore = 1'b0;
    logic [2:0]  reqFunct3 = 3'b010;
    logic        reqReady, respValid, respError, busy, stickyError;
    MemoryMode_t memoryMode;
    logic [2:0]  funct3;
    logic        memoryUnalignedAccess, memoryBadFunct3;
    logic [1:0]  errorCount;

    logic [31:0] addr = 32'h100;
    logic [31:0] wdata = 32'h0;
    logic [31:0] mem [0:15];
    logic [31:0] memoryOutput;
    logic [3:0]  idx;

    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;
    Resp_t sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    memory_access_sequencer #(.ERR_COUNT_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqStore(reqStore),
        .reqFunct3(reqFunct3), .reqReady(reqReady), .respValid(respValid),
        .respError(respError), .busy(busy), .memoryMode(memoryMode), .funct3(funct3),
        .memoryUnalignedAccess(memoryUnalignedAccess), .memoryBadFunct3(memoryBadFunct3),
        .stickyError(stickyError), .errorCount(errorCount)
    );

    // Controller model: combinational flags, write merged on the STORE cycle
    assign idx = addr[5:2];
    assign memoryOutput = mem[idx];
    assign memoryUnalignedAccess = (funct3[1:0] == 2'b01 && addr[0]) ||
                                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign memoryBadFunct3 = (funct3[1:0] == 2'b11) || (memoryMode != LOAD && funct3[2]);

    always @(posedge clock) begin
        if (memoryMode == STORE) begin
            case (funct3[1:0])
                2'b00:   mem[idx][8*addr[1:0] +: 8] <= wdata[7:0];
                2'b01:   mem[idx][16*addr[1] +: 16] <= wdata[15:0];
                default: mem[idx] <= wdata;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (respValid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got respValid=1 expected none (cycle %0d)", cycle);
            end else begin
                Resp_t e;
                e = sb.pop_front();
                check("resp_cycle", cycle, e.cyc);
                check("resp_error", {31'b0, respError}, {31'b0, e.err});
                if (e.chkData) check("load_data", memoryOutput, e.data);
            end
        end
    end

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle
    task automatic doReq(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic expErr, input logic chk,
                         input logic [31:0] expData);
        Resp_t e;
        reqValid = 1'b1; reqStore = st; reqFunct3 = f3; addr = a; wdata = d;
        #1;
        check("accept_ready", {31'b0, reqReady}, 32'd1);
        check("accept_mode", 32'(memoryMode), st ? 32'(STORE_PRELOAD) : 32'(LOAD));
        e.err = expErr; e.chkData = chk; e.data = expData;
        e.cyc = cycle + ((st && !expErr) ? 2 : 1);
        sb.push_back(e);
        @(posedge clock); #1;
        reqValid = 1'b0;
        if (st && !expErr) begin
            check("write_mode", 32'(memoryMode), 32'(STORE));
            check("write_busy", {30'b0, busy, reqReady}, 32'd2);
            @(posedge clock); #1;
        end
        check("respond_mode", 32'(memoryMode), 32'(LOAD));
        check("respond_busy", {30'b0, busy, reqReady}, 32'd2);
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hCAFEF00D;
        mem[2] = 32'h55667788;
        #22 reset = 1'b1;
        @(posedge clock); #1;
        check("rst_ready", {31'b0, reqReady}, 32'd1);
        check("rst_mode", 32'(memoryMode), 32'(LOAD));
        check("rst_flags", {28'b0, respValid, respError, busy, stickyError}, 32'd0);
        check("rst_count", {30'b0, errorCount}, 32'd0);

        doReq(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h11223344);
        doReq(1'b1, 3'b000, 32'h101, 32'h000000AB, 1'b0, 1'b0, 32'h0);
        doReq(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1122AB44);

        doReq(1'b1, 3'b010, 32'h102, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
        check("err_sticky", {31'b0, stickyError}, 32'd1);
        check("err_count", {30'b0, errorCount}, 32'd1);
        doReq(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1122AB44);

        // Back-to-back loads with reqValid held high
        begin
            Resp_t e;
            reqValid = 1'b1; reqStore = 1'b0; reqFunct3 = 3'b010; addr = 32'h104;
            #1;
            e.err = 1'b0; e.chkData = 1'b1; e.data = 32'hCAFEF00D; e.cyc = cycle + 1;
            sb.push_back(e);
            @(posedge clock); #1;
            check("hold_ready_A1", {31'b0, reqReady}, 32'd0);
            @(posedge clock); #1;
            check("hold_ready_A2", {31'b0, reqReady}, 32'd1);
            e.cyc = cycle + 1;
            sb.push_back(e);
            @(posedge clock); #1;
            reqValid = 1'b0;
            check("hold_respond", {31'b0, busy}, 32'd1);
            @(posedge clock); #1;
        end

        // Reset dropped during WRITE aborts the store with no response
        reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'b010; addr = 32'h108; wdata = 32'hDEADBEEF;
        @(posedge clock); #1;
        reqValid = 1'b0;
        check("abort_write_mode", 32'(memoryMode), 32'(STORE));
        #2 reset = 1'b0;
        #1;
        check("abort_mode", 32'(memoryMode), 32'(LOAD));
        check("abort_idle", {30'b0, busy, reqReady}, 32'd1);
        @(posedge clock); #3 reset = 1'b1;
        @(posedge clock); #1;
        check("abort_ready", {31'b0, reqReady}, 32'd1);
        check("abort_clear", {29'b0, stickyError, errorCount}, 32'd0);
        doReq(1'b0, 3'b010, 32'h108, 32'h0, 1'b0, 1'b1, 32'h55667788);

        // Saturation of the 2-bit error counter
        doReq(1'b1, 3'b010, 32'h102, 32'h1, 1'b1, 1'b0, 32'h0);
        check("sat_count1", {29'b0, stickyError, errorCount}, 32'h5);
        doReq(1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 1'b0, 32'h0);
        check("sat_count2", {29'b0, stickyError, errorCount}, 32'h6);
        doReq(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
        check("sat_count3", {29'b0, stickyError, errorCount}, 32'h7);
        doReq(1'b1, 3'b100, 32'h100, 32'h2, 1'b1, 1'b0, 32'h0);
        check("sat_count4", {29'b0, stickyError, errorCount}, 32'h7);
        doReq(1'b1, 3'b001, 32'h103, 32'h3, 1'b1, 1'b0, 32'h0);
        check("sat_count5", {29'b0, stickyError, errorCount}, 32'h7);
        doReq(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1122AB44);

        @(posedge clock); #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
